// File: rtl/apb_reg_arbiter.sv
// -----------------------------------------------------------------------------
// apb_reg_arbiter
//
// Two-requester APB master. Requests from m0/m1 are arbitrated round-robin
// (m0 first after reset), the winner's transfer attributes are captured on
// grant, and a single APB transfer is run: SETUP -> ACCESS -> DONE. The
// grantee receives a one-cycle ack in DONE together with its read data and
// error flag. Each requester's rdata/err hold until that requester's next ack.
//
// Optional build macro: APB_ARB_TIMEOUT_EN
//   When defined, an 8-bit counter bounds the number of ACCESS wait cycles.
//   After TIMEOUT_CYCLES cycles without pready the transfer is closed with
//   err=1 and rdata=0. When undefined, ACCESS waits for pready indefinitely
//   and no counter exists.
//
// Parameters
//   ADDR_WIDTH      APB address width
//   DATA_WIDTH      APB data width (STRB_WIDTH = DATA_WIDTH/8)
//   TIMEOUT_CYCLES  ACCESS wait limit, 1..255 (used only with the macro)
//
// Ports
//   pclk, preset          clock, synchronous active-high reset
//   mN_req/write/addr/    requester N transfer request and attributes;
//   wdata/strb/prot       request is held until mN_ack
//   mN_ack                one-cycle completion pulse
//   mN_rdata, mN_err      completion data/error, valid with mN_ack
//   psel, penable, pwrite APB control outputs
//   paddr, pwdata, pstrb, APB payload outputs (held outside SETUP/ACCESS)
//   pprot
//   pready, pslverr,      APB slave response
//   prdata
//   busy                  high whenever the FSM is not IDLE
//   grant_id              current or most recent grantee
//
// FSM states
//   state  | meaning
//   IDLE   | no transfer; arbitrate requests
//   SETUP  | psel=1, penable=0, payload presented
//   ACCESS | psel=1, penable=1, waiting for pready (or timeout)
//   DONE   | psel=0, grantee ack pulse, no arbitration
// -----------------------------------------------------------------------------
module apb_reg_arbiter #(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                  pclk,
    input  logic                  preset,

    input  logic                  m0_req,
    input  logic                  m0_write,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic [STRB_WIDTH-1:0] m0_strb,
    input  logic [2:0]            m0_prot,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_err,

    input  logic                  m1_req,
    input  logic                  m1_write,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic [STRB_WIDTH-1:0] m1_strb,
    input  logic [2:0]            m1_prot,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_err,

    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic [STRB_WIDTH-1:0] pstrb,
    output logic [2:0]            pprot,
    input  logic                  pready,
    input  logic                  pslverr,
    input  logic [DATA_WIDTH-1:0] prdata,

    output logic                  busy,
    output logic                  grant_id
);

    // Elaboration-time guard on the wait limit range.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("apb_reg_arbiter: TIMEOUT_CYCLES must be within 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                  state_q,    state_d;
    logic                    rr_ptr_q,   rr_ptr_d;
    logic                    grant_id_q, grant_id_d;
    logic                    psel_q,     psel_d;
    logic                    penable_q,  penable_d;
    logic                    busy_q,     busy_d;
    logic                    pwrite_q,   pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q,    paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q,   pwdata_d;
    logic [STRB_WIDTH-1:0]   pstrb_q,    pstrb_d;
    logic [2:0]              pprot_q,    pprot_d;
    logic                    m0_ack_q,   m0_ack_d;
    logic                    m1_ack_q,   m1_ack_d;
    logic [DATA_WIDTH-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DATA_WIDTH-1:0]   m1_rdata_q, m1_rdata_d;
    logic                    m0_err_q,   m0_err_d;
    logic                    m1_err_q,   m1_err_d;

`ifdef APB_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0]              tmo_cnt_q,  tmo_cnt_d;
`endif

    // Arbitration and transfer-completion helpers.
    logic                    gnt_sel;
    logic                    sel_write;
    logic                    res_valid;
    logic [DATA_WIDTH-1:0]   res_rdata;
    logic                    res_err;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        pwrite_d   = pwrite_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        pstrb_d    = pstrb_q;
        pprot_d    = pprot_q;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        m0_err_d   = m0_err_q;
        m1_err_d   = m1_err_q;
        res_valid  = 1'b0;
        res_rdata  = '0;
        res_err    = 1'b0;

        // A sole requester wins outright; a tie goes to the pointer.
        gnt_sel   = (m0_req && m1_req) ? rr_ptr_q : m1_req;
        sel_write = gnt_sel ? m1_write : m0_write;

        unique case (state_q)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    state_d    = ST_SETUP;
                    grant_id_d = gnt_sel;
                    rr_ptr_d   = ~gnt_sel;
                    pwrite_d   = sel_write;
                    paddr_d    = gnt_sel ? m1_addr  : m0_addr;
                    pwdata_d   = gnt_sel ? m1_wdata : m0_wdata;
                    pprot_d    = gnt_sel ? m1_prot  : m0_prot;
                    // Reads never carry byte strobes on the bus.
                    pstrb_d    = sel_write ? (gnt_sel ? m1_strb : m0_strb) : '0;
                end
            end

            ST_SETUP: begin
                state_d = ST_ACCESS;
            end

            ST_ACCESS: begin
                if (pready) begin
                    state_d   = ST_DONE;
                    res_valid = 1'b1;
                    res_rdata = pwrite_q ? '0 : prdata;
                    res_err   = pslverr;
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LIMIT) begin
                    state_d   = ST_DONE;
                    res_valid = 1'b1;
                    res_rdata = '0;
                    res_err   = 1'b1;
                end
`endif
            end

            ST_DONE: begin
                // No arbitration here: a held request is seen next IDLE.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Completion is routed to whoever owns the current transfer.
        if (res_valid) begin
            if (grant_id_q) begin
                m1_ack_d   = 1'b1;
                m1_rdata_d = res_rdata;
                m1_err_d   = res_err;
            end else begin
                m0_ack_d   = 1'b1;
                m0_rdata_d = res_rdata;
                m0_err_d   = res_err;
            end
        end

        // Bus controls are decoded from the next state so they are flops.
        psel_d    = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d = (state_d == ST_ACCESS);
        busy_d    = (state_d != ST_IDLE);
    end

`ifdef APB_ARB_TIMEOUT_EN
    // Counts wait cycles only while staying in ACCESS; any exit clears it.
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == ST_ACCESS && state_d == ST_ACCESS) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
    end
`endif

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= 1'b0;
            grant_id_q <= 1'b0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            busy_q     <= 1'b0;
            pwrite_q   <= 1'b0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            pstrb_q    <= '0;
            pprot_q    <= '0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            m0_err_q   <= 1'b0;
            m1_err_q   <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            tmo_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            busy_q     <= busy_d;
            pwrite_q   <= pwrite_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            pstrb_q    <= pstrb_d;
            pprot_q    <= pprot_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            m0_err_q   <= m0_err_d;
            m1_err_q   <= m1_err_d;
`ifdef APB_ARB_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
`endif
        end
    end

    assign psel     = psel_q;
    assign penable  = penable_q;
    assign pwrite   = pwrite_q;
    assign paddr    = paddr_q;
    assign pwdata   = pwdata_q;
    assign pstrb    = pstrb_q;
    assign pprot    = pprot_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;
    assign m0_ack   = m0_ack_q;
    assign m1_ack   = m1_ack_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign m0_err   = m0_err_q;
    assign m1_err   = m1_err_q;

endmodule

// File: tb/tb_apb_reg_arbiter.sv
// Bench for apb_reg_arbiter: directed transfers, expected completions queued
// in a scoreboard and popped by a monitor whenever an ack is presented.
module tb_apb_reg_arbiter;

    logic        pclk;
    logic        preset;
    logic        m0_req, m0_write, m1_req, m1_write;
    logic [15:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_strb, m1_strb;
    logic [2:0]  m0_prot, m1_prot;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        psel, penable, pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready, pslverr;
    logic [31:0] prdata;
    logic        busy, grant_id;

    apb_reg_arbiter #(
        .ADDR_WIDTH    (16),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .pclk    (pclk),     .preset  (preset),
        .m0_req  (m0_req),   .m0_write(m0_write), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_strb (m0_strb),  .m0_prot(m0_prot),
        .m0_ack  (m0_ack),   .m0_rdata(m0_rdata), .m0_err (m0_err),
        .m1_req  (m1_req),   .m1_write(m1_write), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_strb (m1_strb),  .m1_prot(m1_prot),
        .m1_ack  (m1_ack),   .m1_rdata(m1_rdata), .m1_err (m1_err),
        .psel    (psel),     .penable (penable),  .pwrite (pwrite),
        .paddr   (paddr),    .pwdata  (pwdata),   .pstrb  (pstrb),
        .pprot   (pprot),    .pready  (pready),   .pslverr(pslverr),
        .prdata  (prdata),   .busy    (busy),     .grant_id(grant_id)
    );

    typedef struct {
        bit          id;
        logic [31:0] rdata;
        bit          err;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fails  = 0;
    int          cyc      = 0;

    // Slave behaviour knobs and observations.
    int          slave_ws    = 0;
    bit          slave_hang  = 0;
    bit          slave_err   = 0;
    logic [31:0] slave_rdata = '0;
    int          pen_cnt     = 0;

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    always @(posedge pclk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge pclk);
            if (m0_ack && m1_ack) begin
                n_checks++;
                n_fails++;
                $display("FAIL ack_onehot: both acks high, required at most one (cycle %0d)", cyc);
            end else if (m0_ack || m1_ack) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL unexpected_ack: m0_ack=%0b m1_ack=%0b, required none (cycle %0d)",
                             m0_ack, m1_ack, cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("ack_id",    32'(m1_ack), 32'(e.id));
                    chk("ack_rdata", m1_ack ? m1_rdata : m0_rdata, e.rdata);
                    chk("ack_err",   32'(m1_ack ? m1_err : m0_err), 32'(e.err));
                    chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    endtask

    task automatic slave();
        int acc    = 0;
        bit in_acc = 0;
        forever begin
            @(negedge pclk);
            prdata  = slave_rdata;
            pslverr = slave_err;
            if (psel && penable) begin
                pready  = !slave_hang && (acc == slave_ws);
                acc++;
                pen_cnt = in_acc ? pen_cnt + 1 : 1;
                in_acc  = 1;
            end else begin
                pready = 1'b0;
                acc    = 0;
                in_acc = 0;
            end
        end
    endtask

    task automatic set_m(input bit id, input bit wr, input logic [15:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input logic [2:0] prot);
        if (id) begin
            m1_write = wr; m1_addr = addr; m1_wdata = wdata;
            m1_strb  = strb; m1_prot = prot; m1_req = 1'b1;
        end else begin
            m0_write = wr; m0_addr = addr; m0_wdata = wdata;
            m0_strb  = strb; m0_prot = prot; m0_req = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge pclk); preset = 1'b1;
        @(negedge pclk);
        @(negedge pclk); preset = 1'b0;
    endtask

    // One transfer by a single requester; exp_lat is the ack cycle relative
    // to the cycle the request is raised. pulse_other briefly raises the
    // other requester while this transfer is in ACCESS.
    task automatic single(input bit id, input bit wr, input logic [15:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [2:0] prot, input logic [31:0] exp_rd,
                          input bit exp_err, input int exp_lat, input bit pulse_other);
        int c;
        bit got;
        logic [3:0] exp_strb;
        exp_strb = wr ? strb : 4'h0;
        @(negedge pclk);
        c = cyc;
        set_m(id, wr, addr, wdata, strb, prot);
        sb_q.push_back('{id, exp_rd, exp_err, c + exp_lat});
        @(negedge pclk);
        chk("setup_psel",    32'(psel),     32'd1);
        chk("setup_penable", 32'(penable),  32'd0);
        chk("setup_busy",    32'(busy),     32'd1);
        chk("setup_grant",   32'(grant_id), 32'(id));
        chk("setup_paddr",   32'(paddr),    32'(addr));
        chk("setup_pwrite",  32'(pwrite),   32'(wr));
        chk("setup_pstrb",   32'(pstrb),    32'(exp_strb));
        chk("setup_pwdata",  pwdata,        wdata);
        chk("setup_pprot",   32'(pprot),    32'(prot));
        @(negedge pclk);
        chk("access_psel",    32'(psel),    32'd1);
        chk("access_penable", 32'(penable), 32'd1);
        chk("access_paddr",   32'(paddr),   32'(addr));
        chk("access_pwrite",  32'(pwrite),  32'(wr));
        chk("access_pstrb",   32'(pstrb),   32'(exp_strb));
        if (pulse_other) begin
            if (id) m0_req = 1'b1; else m1_req = 1'b1;
            @(negedge pclk);
            if (id) m0_req = 1'b0; else m1_req = 1'b0;
        end
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            if (id ? m1_ack : m0_ack) got = 1;
            else @(negedge pclk);
        end
        chk("single_ack_seen", 32'(got), 32'd1);
        if (id) m1_req = 1'b0; else m0_req = 1'b0;
        @(negedge pclk);
        chk("after_busy", 32'(busy), 32'd0);
        chk("after_psel", 32'(psel), 32'd0);
    endtask

    // Both requesters raised together and held; n completions alternate
    // m0, m1, ... four cycles apart starting at cycle 3.
    task automatic both_reqs(input int n, input logic [31:0] rd);
        int c;
        @(negedge pclk);
        c = cyc;
        set_m(0, 1'b0, 16'h0020, 32'h0, 4'h0, 3'b000);
        set_m(1, 1'b0, 16'h0030, 32'h0, 4'h0, 3'b001);
        for (int k = 0; k < n; k++)
            sb_q.push_back('{bit'(k % 2), rd, 1'b0, c + 3 + 4 * k});
        @(negedge pclk);
        chk("both_first_grant", 32'(grant_id), 32'd0);
        for (int i = 0; i < 100 && cyc < c + 4 * (n - 1) + 1; i++) @(negedge pclk);
        m0_req = 1'b0;
        m1_req = 1'b0;
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge pclk);
        chk("both_drained", 32'(sb_q.size()), 32'd0);
        @(negedge pclk);
        chk("both_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int c;
        preset  = 1'b1;
        m0_req = 0; m0_write = 0; m0_addr = '0; m0_wdata = '0; m0_strb = '0; m0_prot = '0;
        m1_req = 0; m1_write = 0; m1_addr = '0; m1_wdata = '0; m1_strb = '0; m1_prot = '0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        fork
            monitor();
            slave();
        join_none

        repeat (3) @(negedge pclk);
        chk("rst_psel",     32'(psel),     32'd0);
        chk("rst_penable",  32'(penable),  32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_grant",    32'(grant_id), 32'd0);
        chk("rst_paddr",    32'(paddr),    32'd0);
        chk("rst_pstrb",    32'(pstrb),    32'd0);
        chk("rst_m0_rdata", m0_rdata,      32'd0);
        chk("rst_m1_err",   32'(m1_err),   32'd0);
        preset = 1'b0;

        // m0 read, immediate pready.
        slave_ws = 0; slave_err = 0; slave_rdata = 32'hDEADBEEF;
        single(0, 1'b0, 16'h0010, 32'h0, 4'h0, 3'b000, 32'hDEADBEEF, 1'b0, 3, 1'b0);

        // m0 read with strobes driven: bus strobes must still be zero.
        slave_rdata = 32'h12345678;
        single(0, 1'b0, 16'h0004, 32'h0, 4'hF, 3'b000, 32'h12345678, 1'b0, 3, 1'b0);

        // Round-robin from reset: m0, m1, m0, m1 at cycles 3, 7, 11, 15.
        do_reset();
        slave_rdata = 32'h00001111;
        both_reqs(4, 32'h00001111);

        // m1 write, three wait states then slave error; m0 pulses while busy.
        slave_ws = 3; slave_err = 1; slave_rdata = 32'hFFFFFFFF;
        single(1, 1'b1, 16'h0040, 32'hCAFEF00D, 4'hF, 3'b010, 32'h0, 1'b1, 6, 1'b1);
        chk("ws_penable_cycles", 32'(pen_cnt), 32'd4);
        chk("m0_rdata_held",     m0_rdata,     32'h00001111);
        slave_ws = 0; slave_err = 0;

`ifdef APB_ARB_TIMEOUT_EN
        // Slave never ready: ACCESS lasts TIMEOUT_CYCLES+1 cycles.
        slave_hang = 1; slave_rdata = 32'hBAD0BAD0;
        single(0, 1'b0, 16'h0060, 32'h0, 4'h0, 3'b001, 32'h0, 1'b1, 7, 1'b0);
        chk("tmo_penable_cycles", 32'(pen_cnt), 32'd5);
        slave_hang = 0;
`endif

        // Reset during ACCESS of an m0 transfer; pointer must return to m0.
        slave_hang = 1;
        @(negedge pclk);
        c = cyc;
        set_m(0, 1'b0, 16'h0050, 32'h0, 4'h0, 3'b000);
        @(negedge pclk);
        @(negedge pclk);
        chk("abort_in_access", 32'(penable), 32'd1);
        preset = 1'b1;
        m0_req = 1'b0;
        @(negedge pclk);
        chk("abort_psel",  32'(psel),     32'd0);
        chk("abort_busy",  32'(busy),     32'd0);
        chk("abort_ack",   32'(m0_ack),   32'd0);
        chk("abort_grant", 32'(grant_id), 32'd0);
        chk("abort_cycle", 32'(cyc),      32'(c + 3));
        preset = 1'b0;
        slave_hang = 0;
        slave_rdata = 32'h55AA55AA;
        both_reqs(2, 32'h55AA55AA);

        repeat (3) @(negedge pclk);
        chk("final_queue_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/apb_reg_arbiter.md
APB_REG_ARBITER -- requirements
Module: apb_reg_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, APB address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, APB data width; STRB_WIDTH = DATA_WIDTH/8.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 255, range 1..255, access-phase wait limit.
REQ-004 Ports SHALL be exactly as follows, clock and reset first:
- pclk  in  1  sole clock.
- preset  in  1  synchronous, active-high reset.
- mN_req  in  1  requester N (N=0,1) transfer request, held until mN_ack.
- mN_write  in  1  1 = write, 0 = read.
- mN_addr  in  ADDR_WIDTH  transfer address.
- mN_wdata  in  DATA_WIDTH  write data.
- mN_strb  in  STRB_WIDTH  write byte strobes.
- mN_prot  in  3  protection attribute.
- mN_ack  out  1  one-cycle completion pulse.
- mN_rdata  out  DATA_WIDTH  read data, valid with mN_ack.
- mN_err  out  1  error, valid with mN_ack.
- psel, penable, pwrite  out  1 each  APB master controls.
- paddr / pwdata / pstrb / pprot  out  ADDR_WIDTH / DATA_WIDTH / STRB_WIDTH / 3  APB master payload.
- pready, pslverr  in  1 each  APB slave response.
- prdata  in  DATA_WIDTH  APB slave read data.
- busy  out  1  high whenever the state is not IDLE.
- grant_id  out  1  index of the current or most recent grantee.

Function
REQ-005 The FSM SHALL have four states, IDLE, SETUP, ACCESS and DONE; transitions are IDLE->SETUP on grant, SETUP->ACCESS unconditionally, ACCESS->DONE on pready=1 or timeout, and DONE->IDLE unconditionally.
REQ-006 In IDLE, the block SHALL grant a sole requester; with both requests high, it SHALL grant the requester selected by a round-robin pointer.
REQ-007 After each grant to N, the round-robin pointer SHALL point to the other requester.
REQ-008 On grant, the block SHALL register the grantee's write, addr, wdata, strb and prot, and SHALL drive them on the APB outputs during SETUP and ACCESS.
REQ-009 The APB payload outputs SHALL hold their last value in IDLE and DONE.
REQ-010 pstrb SHALL be 0 for reads.
REQ-011 Signalling SHALL be psel=1/penable=0 in SETUP, psel=1/penable=1 in ACCESS, and psel=0/penable=0 in IDLE and DONE.
REQ-012 pslverr and prdata SHALL be sampled only in ACCESS with pready=1.
REQ-013 On that sample, the block SHALL register rdata (prdata for reads, 0 for writes) and err (pslverr).
REQ-014 In DONE, only the grantee's mN_ack SHALL be 1; mN_rdata and mN_err SHALL be valid in that cycle and hold until the next ack to N.
REQ-015 Minimum latency SHALL be req in IDLE at cycle 0 -> SETUP at 1 -> ACCESS at 2 -> ack at 3 (pready=1 at cycle 2) -> IDLE at 4, giving 4 cycles per back-to-back transfer.
REQ-016 A request withdrawn before grant SHALL be ignored; a request withdrawn after grant SHALL still complete and be acked.
REQ-017 The block SHALL not arbitrate in DONE, so a requester that keeps its request high after ack is re-arbitrated in the following IDLE.

Reset
REQ-018 preset=1 at any clock edge SHALL force IDLE with psel, penable, pwrite, mN_ack, mN_err, busy and grant_id at 0, paddr, pwdata, pstrb, pprot and mN_rdata at 0, the round-robin pointer at 0 (m0 first), and the timeout counter at 0.
REQ-019 A transfer aborted by reset SHALL never be acked.

Configuration
REQ-020 With macro APB_ARB_TIMEOUT_EN defined, an 8-bit counter SHALL count ACCESS cycles with pready=0 and clear on leaving ACCESS.
REQ-021 When that counter reaches TIMEOUT_CYCLES, the block SHALL go to DONE with err=1 and rdata=0.
REQ-022 Without APB_ARB_TIMEOUT_EN, ACCESS SHALL wait indefinitely for pready, and no counter logic SHALL exist.

Verification
REQ-023 m0 read of addr 0x0010, slave pready=1 immediately with prdata=0xDEADBEEF -> m0_ack at cycle 3, m0_rdata=0xDEADBEEF, m0_err=0.
REQ-024 m0 and m1 requesting together after reset, held continuously -> grants m0, m1, m0, m1 with acks at cycles 3, 7, 11, 15.
REQ-025 m1 write with strb=0xF and slave inserting 3 wait states, then pslverr=1 -> penable high for 4 cycles, m1_ack with m1_err=1 and m1_rdata=0.
REQ-026 preset asserted during ACCESS -> next cycle psel=0, busy=0, no ack; the next request is granted to m0 first.
REQ-027 APB_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, pready held 0 -> ACCESS for 5 cycles, then ack with err=1 and rdata=0.
REQ-028 m0 read of 0x0004 -> pstrb=0 and pwrite=0 in both SETUP and ACCESS, with paddr stable at 0x0004.
